// File: rtl/regfile_writeback.sv
// Register file write-port owner: merges un-stallable ALU results with a small
// FIFO of long-latency results and tracks outstanding long-latency writes.

module regfile_writeback_sb_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic busy,
  output logic waw
);
  // An issue to a register that is still outstanding and not retiring now.
  assign waw = set && busy && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;
  end
endmodule

module regfile_writeback #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int LU_DEPTH = 2,
  localparam int IW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [IW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lu_issue,
  input  logic [IW-1:0]   lu_issue_rd,
  input  logic            lu_valid,
  input  logic [IW-1:0]   lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic            rf_we,
  output logic [IW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [IW-1:0]   q_rs1,
  input  logic [IW-1:0]   q_rs2,
  output logic            q_busy1,
  output logic            q_busy2,
  output logic [NREG-1:0] pending,
  output logic            waw_err
);
  localparam int PW = $clog2(LU_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IW-1:0]   rd;
    logic [XLEN-1:0] data;
  } lu_entry_t;

  lu_entry_t       fifo_mem [LU_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_empty, fifo_full;
  logic            push, pop, alu_win;
  logic            rf_src_lu;
  lu_entry_t       head;
  logic [NREG-1:0] waw_vec;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(LU_DEPTH));
  assign lu_ready   = !fifo_full;
  assign head       = fifo_mem[rd_ptr];

  // x0 results are accepted on the handshake but never stored.
  assign push    = lu_valid && lu_ready && (lu_rd != '0);
  assign alu_win = alu_valid && (alu_rd != '0);
  assign pop     = !alu_win && !fifo_empty;

  // FIFO storage carries no reset; occupancy is governed by count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rd: lu_rd, data: lu_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write port register; rd/wdata hold their last value on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wdata  <= '0;
      rf_src_lu <= 1'b0;
    end else if (alu_win) begin
      rf_we     <= 1'b1;
      rf_rd     <= alu_rd;
      rf_wdata  <= alu_data;
      rf_src_lu <= 1'b0;
    end else if (pop) begin
      rf_we     <= 1'b1;
      rf_rd     <= head.rd;
      rf_wdata  <= head.data;
      rf_src_lu <= 1'b1;
    end else begin
      rf_we     <= 1'b0;
      rf_src_lu <= 1'b0;
    end
  end

  // Pending bits retire when the committed write on rf_* came from the FIFO.
  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign pending[r] = 1'b0;
      assign waw_vec[r] = 1'b0;
    end else begin : g_reg
      logic set, clr;
      assign set = lu_issue && (lu_issue_rd == IW'(r));
      assign clr = rf_we && rf_src_lu && (rf_rd == IW'(r));
      regfile_writeback_sb_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .set  (set),
        .clr  (clr),
        .busy (pending[r]),
        .waw  (waw_vec[r])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          waw_err <= 1'b0;
    else if (|waw_vec) waw_err <= 1'b1;
  end

  assign q_busy1 = pending[q_rs1];
  assign q_busy2 = pending[q_rs2];
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer end of the register file write port: owns the single write port (rf_we/rf_rd/rf_wdata) and is the only block that drives it.
- Merges two result sources:
  - single-cycle ALU results, which cannot be back-pressured;
  - long-latency unit results (load/mul/div), taken over a valid/ready handshake and buffered in a small FIFO.
- Keeps a pending-write scoreboard so decode can stall on operands that are not yet written back.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (index width = $clog2(NREG))
LU_DEPTH, 2, long-latency result FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
lu_issue  in  1  long-latency op issued this cycle
lu_issue_rd  in  5  destination of issued op
lu_valid  in  1  long-latency result offered
lu_rd  in  5  result destination
lu_data  in  XLEN  result data
lu_ready  out  1  result accepted when lu_valid && lu_ready
rf_we  out  1  register file write enable (registered)
rf_rd  out  5  write address (registered)
rf_wdata  out  XLEN  write data (registered)
q_rs1  in  5  scoreboard query 1
q_rs2  in  5  scoreboard query 2
q_busy1  out  1  q_rs1 has an outstanding long-latency write
q_busy2  out  1  q_rs2 has an outstanding long-latency write
pending  out  NREG  scoreboard mask, bit0 always 0
waw_err  out  1  sticky: issue to an already-pending rd

Behaviour:
- Reset (async, rst=1):
  - rf_we=0, rf_rd=0, rf_wdata=0;
  - FIFO empty, so lu_ready=1;
  - pending=0, waw_err=0.
- Write port slot selection, one winner per cycle:
  - ALU wins when alu_valid && alu_rd!=0.
  - Otherwise the FIFO head is popped if the FIFO is non-empty.
  - Otherwise there is no write.
  - The winner is registered onto rf_*: latency is 1 cycle from the selection cycle to rf_we=1.
- ALU with alu_rd=0: discarded and does not consume the slot, so the FIFO may pop that cycle.
- Idle cycles: rf_we=0; rf_rd and rf_wdata hold their last value.
- Long-latency handshake:
  - lu_ready = !full, derived from the registered count; there is no same-cycle pop pass-through.
  - On lu_valid && lu_ready, {lu_rd, lu_data} is pushed.
  - lu_rd=0 is accepted and dropped (no push).
  - Push and pop in the same cycle keep the count unchanged.
  - FIFO order is strict.
- Scoreboard:
  - lu_issue && lu_issue_rd!=0 sets pending[lu_issue_rd] at the next edge.
  - pending[r] clears at the edge where rf_we=1 and rf_rd=r for a FIFO-sourced write, i.e. when the register file commits.
  - ALU writes never touch pending.
  - Set and clear of the same r in the same cycle: set wins.
  - lu_issue to an r already pending and not clearing that cycle: waw_err sets (sticky until reset) and pending[r] stays 1.
- Query:
  - q_busyN = pending[q_rsN], combinational; 0 when q_rsN=0.
- Starvation: continuous ALU writes starve the FIFO and hold lu_ready=0. No guard is provided; the pipeline guarantees gaps.
- Reset mid-operation: FIFO contents and pending bits are lost; rf_we drops to 0 immediately (async).

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- lu_issue rd=7; 3 cycles later lu_valid rd=7, data=0x12345678 with ALU idle -> pending[7]=1 and q_busy1=1 (q_rs1=7) until rf_we=1/rf_rd=7 commits; pending[7]=0 after that edge.
- ALU valid every cycle for 4 cycles while lu_valid is held -> two LU results accepted, then lu_ready=0; no LU write during ALU cycles; both LU writes appear in order in the two cycles after the ALU burst.
- alu_rd=0 and FIFO holding rd=3 in the same cycle -> rf_rd=3 written next cycle; x0 is never written.
- lu_issue rd=9 twice with no intervening writeback -> waw_err=1 and stays 1; a lu_issue rd=9 in the same cycle rd=9 clears -> waw_err unchanged, pending[9]=1.
- Assert rst while the FIFO is full and rf_we=1 -> rf_we=0, lu_ready=1, pending=0 asynchronously, before the next clock edge.
